// File: rtl/addsub_bist_pkg.sv
// Shared types and constants for the addsub_bist self-test controller:
// FSM state encoding, LFSR taps/seeds, saturation limits, LFSR helpers.
package addsub_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // x^16 + x^14 + x^13 + x^11 + 1 -> state bits 15, 13, 12, 10
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;
    localparam logic [15:0] DEF_SEED_A = 16'hACE1;
    localparam logic [15:0] DEF_SEED_B = 16'h1D0F;
    localparam logic [15:0] SAT_POS    = 16'h7FFF;
    localparam logic [15:0] SAT_NEG    = 16'h8000;
    localparam logic [7:0]  ERR_MAX    = 8'hFF;

    // Fibonacci step: shift left, parity of tapped bits enters bit 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    function automatic logic [15:0] seed_fix(input logic [15:0] s);
        return (s == 16'h0000) ? 16'h0001 : s;
    endfunction

endpackage

// File: rtl/addsub_bist_if.sv
// Bus between the BIST controller (master, drives operands) and the
// saturating adder/subtractor under test (slave, returns sum/overflow).
interface addsub_bist_if;

    logic [15:0] tst_a;
    logic [15:0] tst_b;
    logic        tst_sub;
    logic [15:0] dut_sum;
    logic        dut_ovfl;

    modport master (
        output tst_a, tst_b, tst_sub,
        input  dut_sum, dut_ovfl
    );

    modport slave (
        input  tst_a, tst_b, tst_sub,
        output dut_sum, dut_ovfl
    );

endinterface

// File: rtl/addsub_bist_lfsr16.sv
// 16-bit Fibonacci LFSR used as an operand generator. load has priority
// over step; the reset value is the seed so the block is ready after reset.
module lfsr16
    import addsub_bist_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    // State register: reload from seed, or advance one step.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
        if (!rst_n) begin
            q <= seed;
        end else if (load) begin
            q <= seed;
        end else if (step) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/addsub_bist.sv
// Built-in self-test controller for the saturating 16-bit adder/subtractor.
// Drives pseudo-random operands, checks results against an inline golden
// model, and reports pass / error count / first failing vector index.
// Optional MISR signature output: define ADDSUB_BIST_SIGNATURE_EN.
module addsub_bist
    import addsub_bist_pkg::*;
#(
    parameter int          NUM_VECTORS = 100,
    parameter logic [15:0] SEED_A      = DEF_SEED_A,
    parameter logic [15:0] SEED_B      = DEF_SEED_B
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    addsub_bist_if.master        bus,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [7:0]           err_cnt,
    output logic [15:0]          first_fail_idx
`ifdef ADDSUB_BIST_SIGNATURE_EN
    ,
    output logic [15:0]          sig
`endif
);

    localparam logic [15:0] SEED_A_EFF = seed_fix(SEED_A);
    localparam logic [15:0] SEED_B_EFF = seed_fix(SEED_B);
    localparam logic [15:0] LAST_IDX   = 16'(NUM_VECTORS - 1);

    state_t      state, state_nxt;
    logic [15:0] idx;
    logic [15:0] lfsr_a_q, lfsr_b_q;
    logic [15:0] next_a, next_b;
    logic        start_ok, in_check, last_vec;
    logic [15:0] gold_sum;
    logic        gold_ovfl;
    logic [16:0] ext_res;
    logic        mismatch;

    assign start_ok = start && (state == ST_IDLE || state == ST_DONE);
    assign in_check = (state == ST_CHECK);
    assign last_vec = (idx == LAST_IDX);
    assign next_a   = lfsr_next(lfsr_a_q);
    assign next_b   = lfsr_next(lfsr_b_q);

    lfsr16 u_lfsr_a (
        .clk  (clk),
        .rst_n(rst_n),
        .load (start_ok),
        .step (in_check),
        .seed (SEED_A_EFF),
        .q    (lfsr_a_q)
    );

    lfsr16 u_lfsr_b (
        .clk  (clk),
        .rst_n(rst_n),
        .load (start_ok),
        .step (in_check),
        .seed (SEED_B_EFF),
        .q    (lfsr_b_q)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // FSM next-state logic; start is honoured only in IDLE and DONE.
    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (start_ok) state_nxt = ST_DRIVE;
            ST_DRIVE: state_nxt = ST_CHECK;
            ST_CHECK: state_nxt = last_vec ? ST_DONE : ST_DRIVE;
            ST_DONE:  if (start_ok) state_nxt = ST_DRIVE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Golden saturating result from a 17-bit sign-extended add/sub; the two
    // top bits disagree only when the operand signs allow an overflow.
    always_comb begin
        ext_res   = bus.tst_sub ? ({bus.tst_a[15], bus.tst_a} - {bus.tst_b[15], bus.tst_b})
                                : ({bus.tst_a[15], bus.tst_a} + {bus.tst_b[15], bus.tst_b});
        gold_sum  = ext_res[15:0];
        gold_ovfl = 1'b0;
        if (ext_res[16] != ext_res[15]) begin
            gold_ovfl = 1'b1;
            gold_sum  = ext_res[16] ? SAT_NEG : SAT_POS;
        end
    end

    assign mismatch = (bus.dut_sum != gold_sum) || (bus.dut_ovfl != gold_ovfl);

    // Run bookkeeping and registered operands; operands change only when
    // entering DRIVE so they stay stable across each DRIVE+CHECK pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx            <= 16'd0;
            err_cnt        <= 8'd0;
            first_fail_idx <= 16'd0;
            bus.tst_a      <= 16'd0;
            bus.tst_b      <= 16'd0;
            bus.tst_sub    <= 1'b0;
        end else if (start_ok) begin
            idx            <= 16'd0;
            err_cnt        <= 8'd0;
            first_fail_idx <= 16'd0;
            bus.tst_a      <= SEED_A_EFF;
            bus.tst_b      <= SEED_B_EFF;
            bus.tst_sub    <= SEED_A_EFF[0] ^ SEED_B_EFF[0];
        end else if (in_check) begin
            if (mismatch) begin
                if (err_cnt != ERR_MAX) err_cnt <= err_cnt + 8'd1;
                // err_cnt never wraps, so zero means no earlier mismatch this run.
                if (err_cnt == 8'd0) first_fail_idx <= idx;
            end
            idx <= idx + 16'd1;
            if (!last_vec) begin
                bus.tst_a   <= next_a;
                bus.tst_b   <= next_b;
                bus.tst_sub <= next_a[0] ^ next_b[0];
            end
        end
    end

`ifdef ADDSUB_BIST_SIGNATURE_EN
    // MISR: fold each observed DUT sum into the running signature.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= 16'd0;
        end else if (start_ok) begin
            sig <= 16'd0;
        end else if (in_check) begin
            sig <= {sig[14:0], sig[15] ^ sig[13] ^ sig[12] ^ sig[10]} ^ bus.dut_sum;
        end
    end
`endif

    assign busy = (state == ST_DRIVE) || (state == ST_CHECK);
    assign done = (state == ST_DONE);
    assign pass = done && (err_cnt == 8'd0);

endmodule

// File: tb/tb_addsub_bist.sv
// Self-checking bench for addsub_bist: a behavioural saturating adder acts
// as the unit under test (with fault modes), table-driven full runs, plus
// hand-written sequences for vector order, mid-run reset and restart.
// Signature checks are compiled in with ADDSUB_BIST_SIGNATURE_EN.
module tb_addsub_bist;

    localparam int N0 = 100;
    localparam int N1 = 300;

    localparam int MODE_OK    = 0;   // correct adder
    localparam int MODE_OVFL1 = 1;   // overflow flag tied high
    localparam int MODE_STUCK = 2;   // sum bit 0 stuck at 1
    localparam int MODE_ZERO  = 3;   // sum tied to zero

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start0 = 1'b0, start1 = 1'b0;
    int   mode = MODE_OK;
    int   sel = 0;

    logic        busy0, done0, pass0, busy1, done1, pass1;
    logic [7:0]  err0, err1;
    logic [15:0] ffi0, ffi1;
    logic [15:0] sig0, sig1;

    logic        cur_busy, cur_done, cur_pass;
    logic [7:0]  cur_err;
    logic [15:0] cur_ffi;

    int checks = 0;
    int failures = 0;

    addsub_bist_if bus0 ();
    addsub_bist_if bus1 ();

    always #5 clk = ~clk;

    addsub_bist #(.NUM_VECTORS(N0)) u_bist0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .bus(bus0.master),
        .busy(busy0), .done(done0), .pass(pass0),
        .err_cnt(err0), .first_fail_idx(ffi0)
`ifdef ADDSUB_BIST_SIGNATURE_EN
        , .sig(sig0)
`endif
    );

    addsub_bist #(.NUM_VECTORS(N1)) u_bist1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .bus(bus1.master),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(err1), .first_fail_idx(ffi1)
`ifdef ADDSUB_BIST_SIGNATURE_EN
        , .sig(sig1)
`endif
    );

`ifndef ADDSUB_BIST_SIGNATURE_EN
    assign sig0 = 16'h0;
    assign sig1 = 16'h0;
`endif

    // Reference saturating add/sub using integer arithmetic: {ovfl, sum}.
    function automatic logic [16:0] ref_addsub(input logic [15:0] a, input logic [15:0] b,
                                               input logic sub);
        int sa, sb, r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        r  = sub ? (sa - sb) : (sa + sb);
        if (r > 32767)  return {1'b1, 16'h7FFF};
        if (r < -32768) return {1'b1, 16'h8000};
        return {1'b0, r[15:0]};
    endfunction

    function automatic logic [15:0] ref_lfsr(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Unit under test for instance 0, with selectable fault.
    always_comb begin
        logic [16:0] r;
        r = ref_addsub(bus0.tst_a, bus0.tst_b, bus0.tst_sub);
        bus0.dut_sum  = r[15:0];
        bus0.dut_ovfl = r[16];
        if (mode == MODE_OVFL1) bus0.dut_ovfl = 1'b1;
        if (mode == MODE_STUCK) bus0.dut_sum[0] = 1'b1;
        if (mode == MODE_ZERO)  bus0.dut_sum = 16'h0000;
    end

    // Instance 1 always sees a zero sum with the real overflow flag.
    always_comb begin
        logic [16:0] r;
        r = ref_addsub(bus1.tst_a, bus1.tst_b, bus1.tst_sub);
        bus1.dut_sum  = 16'h0000;
        bus1.dut_ovfl = r[16];
    end

    always_comb begin
        cur_busy = (sel == 0) ? busy0 : busy1;
        cur_done = (sel == 0) ? done0 : done1;
        cur_pass = (sel == 0) ? pass0 : pass1;
        cur_err  = (sel == 0) ? err0  : err1;
        cur_ffi  = (sel == 0) ? ffi0  : ffi1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input int inst, input logic v);
        if (inst == 0) start0 = v;
        else           start1 = v;
    endtask

    // Predict a run of n vectors under a fault mode: raw mismatch count,
    // first failing index, and the signature the MISR should hold.
    task automatic model_run(input int md, input int n, output int errs, output int ffi,
                             output logic [15:0] sg);
        logic [15:0] a, b, s;
        logic        sub, ov;
        logic [16:0] g;
        a = 16'hACE1; b = 16'h1D0F; errs = 0; ffi = 0; sg = 16'h0;
        for (int i = 0; i < n; i++) begin
            sub = a[0] ^ b[0];
            g   = ref_addsub(a, b, sub);
            s   = g[15:0];
            ov  = g[16];
            if (md == MODE_OVFL1) ov = 1'b1;
            if (md == MODE_STUCK) s[0] = 1'b1;
            if (md == MODE_ZERO)  s = 16'h0000;
            if (s != g[15:0] || ov != g[16]) begin
                if (errs == 0) ffi = i;
                errs++;
            end
            sg = {sg[14:0], sg[15] ^ sg[13] ^ sg[12] ^ sg[10]} ^ s;
            a  = ref_lfsr(a);
            b  = ref_lfsr(b);
        end
    endtask

    // Start a run on the selected instance and count busy cycles until done;
    // optionally pulse start again at busy cycle restart_at.
    task automatic run_until_done(input int inst, input int restart_at, input int budget,
                                  output int cycles);
        int guard;
        sel = inst;
        set_start(inst, 1'b1);
        tick();
        set_start(inst, 1'b0);
        cycles = 0;
        guard  = 0;
        while (!cur_done && guard < budget) begin
            if (cycles == restart_at) set_start(inst, 1'b1);
            if (cur_busy) cycles++;
            tick();
            set_start(inst, 1'b0);
            guard++;
        end
        if (!cur_done) check("run_timeout", 32'(guard), 32'(budget + 1));
    endtask

    typedef struct {
        string name;
        int    inst;
        int    mode;
        int    restart_at;
        int    exp_cycles;
        int    exp_err;
        int    exp_ffi;
        logic  exp_pass;
    } run_t;

    run_t runs[4];

    initial begin
        int          cyc, errs, ffi, ovfl_errs, errs50;
        logic [15:0] sg, ea, eb, sig_ok, sig_ok_model, sig_stuck_model;

        model_run(MODE_OVFL1, N0, ovfl_errs, ffi, sg);
        model_run(MODE_OVFL1, 50, errs50, ffi, sg);
        runs[0] = '{"ok",      0, MODE_OK,    -1, 2*N0, 0,   0, 1'b1};
        runs[1] = '{"restart", 0, MODE_OK,    37, 2*N0, 0,   0, 1'b1};
        runs[2] = '{"ovfl1",   0, MODE_OVFL1, -1, 2*N0, (ovfl_errs > 255) ? 255 : ovfl_errs, 0, 1'b0};
        runs[3] = '{"zero300", 1, MODE_OK,    -1, 2*N1, 255, 0, 1'b0};

        // Reset state.
        repeat (3) tick();
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_pass", pass0, 0);
        check("rst_err",  err0,  0);
        check("rst_tst_a", bus0.tst_a, 0);
        rst_n = 1'b1;
        tick();
        check("idle_busy", busy0, 0);
        check("idle_ffi",  ffi0,  0);

        // Vector order, then reset during CHECK of vector 50.
        mode = MODE_OVFL1;
        sel  = 0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("v0_busy",  busy0, 1);
        check("v0_tst_a", bus0.tst_a, 16'hACE1);
        check("v0_tst_b", bus0.tst_b, 16'h1D0F);
        check("v0_sub",   bus0.tst_sub, 0);
        check("v0_ref_sum", bus0.dut_sum, 16'hC9F0);
        ea = 16'hACE1; eb = 16'h1D0F;
        for (int k = 0; k < 4; k++) begin
            check("vec_a", bus0.tst_a, ea);
            check("vec_b", bus0.tst_b, eb);
            check("vec_sub", bus0.tst_sub, ea[0] ^ eb[0]);
            tick();
            check("vec_a_hold", bus0.tst_a, ea);
            tick();
            ea = ref_lfsr(ea);
            eb = ref_lfsr(eb);
        end
        repeat (93) tick();   // now in CHECK of vector 50
        check("mid_busy", busy0, 1);
        check("mid_err", err0, 32'((errs50 > 255) ? 255 : errs50));
        rst_n = 1'b0;
        #2;
        check("arst_busy", busy0, 0);
        check("arst_done", done0, 0);
        check("arst_pass", pass0, 0);
        check("arst_err",  err0,  0);
        check("arst_ffi",  ffi0,  0);
        check("arst_tst_a", bus0.tst_a, 0);
        check("arst_tst_b", bus0.tst_b, 0);
        check("arst_sub",  bus0.tst_sub, 0);
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_busy", busy0, 0);
        check("post_rst_done", done0, 0);
        mode = MODE_OK;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("rerun_tst_a", bus0.tst_a, 16'hACE1);
        check("rerun_tst_b", bus0.tst_b, 16'h1D0F);
        check("rerun_sub",   bus0.tst_sub, 0);
        cyc = 0;
        while (!done0 && cyc < 2*N0 + 20) begin tick(); cyc++; end
        check("rerun_pass", pass0, 1);

        // Table-driven full runs.
        for (int r = 0; r < 4; r++) begin
            mode = runs[r].mode;
            run_until_done(runs[r].inst, runs[r].restart_at, runs[r].exp_cycles + 20, cyc);
            check({runs[r].name, "_cycles"}, 32'(cyc), 32'(runs[r].exp_cycles));
            check({runs[r].name, "_done"}, cur_done, 1);
            check({runs[r].name, "_busy"}, cur_busy, 0);
            check({runs[r].name, "_pass"}, cur_pass, runs[r].exp_pass);
            check({runs[r].name, "_err"},  cur_err,  32'(runs[r].exp_err));
            check({runs[r].name, "_ffi"},  cur_ffi,  32'(runs[r].exp_ffi));
        end
        check("ovfl1_err_nonzero", (ovfl_errs >= 1) ? err0 != 8'd0 : 1'b0, 1);

`ifdef ADDSUB_BIST_SIGNATURE_EN
        model_run(MODE_OK, N0, errs, ffi, sig_ok_model);
        model_run(MODE_STUCK, N0, errs, ffi, sig_stuck_model);
        mode = MODE_OK;
        run_until_done(0, -1, 2*N0 + 20, cyc);
        sig_ok = sig0;
        check("sig_model", sig0, sig_ok_model);
        check("sig_nonzero", sig0 != 16'h0, 1);
        run_until_done(0, -1, 2*N0 + 20, cyc);
        check("sig_repeat", sig0, sig_ok);
        mode = MODE_STUCK;
        run_until_done(0, -1, 2*N0 + 20, cyc);
        check("sig_stuck_model", sig0, sig_stuck_model);
        check("sig_stuck_differs", sig0 != sig_ok, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/addsub_bist.md
# addsub_bist

Built-in self-test controller for the saturating 16-bit adder/subtractor (AddSub_16bit). It sits on the driving side of that unit's interface. It generates pseudo-random a/b/sub vectors with two LFSRs, computes the saturating golden result internally, compares it against the DUT's sum/ovfl and reports pass/fail with an error count. It gives the pipeline's ALU a power-on/debug self-check in hardware instead of only in simulation.

## Interface
- NUM_VECTORS, 100, vectors per run; legal 1..65535
- SEED_A, 16'hACE1, LFSR A seed; zero is replaced by 16'h0001
- SEED_B, 16'h1D0F, LFSR B seed; zero is replaced by 16'h0001
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a run; sampled in IDLE or DONE only
- tst_a  out  16  operand a to DUT (registered)
- tst_b  out  16  operand b to DUT (registered)
- tst_sub  out  1  1 = subtract (registered)
- dut_sum  in  16  DUT result
- dut_ovfl  in  1  DUT overflow flag
- busy  out  1  high in DRIVE/CHECK
- done  out  1  high (level) in DONE
- pass  out  1  err_cnt==0; meaningful only while done
- err_cnt  out  8  mismatch count, saturates at 255
- first_fail_idx  out  16  vector index of first mismatch; 0 if none
- sig  out  16  MISR signature (only with ADDSUB_BIST_SIGNATURE_EN)

## Operation
- FSM states: IDLE, DRIVE, CHECK, DONE.
- IDLE: on start, load both LFSRs with their seeds, clear idx/err_cnt/first_fail_idx/sig, and go to DRIVE.
- DONE: start behaves as in IDLE (restart). Otherwise the FSM holds DONE.
- DRIVE: tst_a/tst_b = LFSR A/B state, tst_sub = A[0]^B[0]. This cycle lets the combinational DUT settle. Next state is CHECK.
- CHECK: compare dut_sum/dut_ovfl against the golden result.
  - On mismatch, err_cnt increments (saturating at 255). On the first mismatch of the run, first_fail_idx is set to idx.
  - Both LFSRs then step, and idx increments.
  - If idx == NUM_VECTORS-1, go to DONE; otherwise go to DRIVE.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1. The state shifts left and the feedback enters bit 0.
- Golden model: form a 17-bit sign-extended sum a+b or a−b.
  - Positive overflow gives 16'h7FFF with ovfl=1.
  - Negative overflow gives 16'h8000 with ovfl=1.
  - Otherwise the result is the low 16 bits with ovfl=0.
  - Overflow is signalled only when the operand signs make it possible: same signs for add, differing signs for sub.
- start while busy is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, LFSRs = seeds. pass reads 0 because done=0.
- A run takes exactly 2·NUM_VECTORS cycles from the first DRIVE to DONE entry.
- busy rises the cycle after start is sampled. done rises the cycle after the last CHECK.
- tst_* are stable for the whole DRIVE+CHECK pair. The DUT path must settle within one cycle.
- Reset asserted mid-run: outputs clear immediately, asynchronously. After release the block sits in IDLE; no partial results are retained.
- err_cnt at 254 plus a mismatch gives 255. Further mismatches leave it at 255.

## Configuration
- ADDSUB_BIST_SIGNATURE_EN defined:
  - sig port exists. Each CHECK cycle it updates as sig = {sig[14:0], sig[15]^sig[13]^sig[12]^sig[10]} ^ dut_sum.
  - sig is cleared on start.
- Not defined: the sig port and MISR logic are absent. All other behaviour is identical.

## Structure
- addsub_bist_pkg holds:
  - the state enum
  - the LFSR tap mask 16'hB400 (taps 16,14,13,11)
  - the default seeds
  - the saturation constants 16'h7FFF and 16'h8000
- One sub-module, lfsr16 (load, step, seed, q), instantiated twice. The golden model stays inline.

## Test plan
- Correct AddSub_16bit connected, NUM_VECTORS=100, start pulse:
  - busy for 200 cycles, then done=1, pass=1, err_cnt=0, first_fail_idx=0.
  - The first vector is tst_a=16'hACE1, tst_b=16'h1D0F, tst_sub=0, which expects sum 16'hC9F0 with ovfl=0.
- dut_ovfl tied to 1, dut_sum from the real DUT:
  - first_fail_idx=0, pass=0.
  - err_cnt equals the number of non-overflow vectors, which is at least 1.
- dut_sum tied to 16'h0000, NUM_VECTORS=300: err_cnt=255 (saturated) at done, pass=0.
- rst_n pulsed low during CHECK of vector 50:
  - all outputs are 0 during reset and the block is in IDLE afterwards.
  - A new start reproduces the vector-0 values above.
- start pulsed again mid-run (busy=1): ignored; the run finishes at the original 2·NUM_VECTORS cycle count.
- With ADDSUB_BIST_SIGNATURE_EN and a correct DUT:
  - two back-to-back runs give identical, nonzero sig.
  - Forcing dut_sum[0] stuck-at-1 changes sig.
